// File: rtl/vga_video_timing.sv
// Parametrised VGA timing generator with a latency-matched pixel pipeline.
// Optional built-in test pattern generator enabled by defining TEST_PATTERN_EN.
module vga_video_timing #(
    parameter int   H_ACTIVE    = 640,
    parameter int   H_FP        = 16,
    parameter int   H_SYNC      = 96,
    parameter int   H_BP        = 48,
    parameter int   V_ACTIVE    = 480,
    parameter int   V_FP        = 10,
    parameter int   V_SYNC      = 2,
    parameter int   V_BP        = 33,
    parameter logic HS_POL      = 1'b0,
    parameter logic VS_POL      = 1'b0,
    parameter int   PIPE_LAT    = 2,
    parameter int   COLOR_DEPTH = 8,
    parameter int   CW          = 10
) (
    input  logic                   vga_clk,
    input  logic                   reset,
    input  logic                   enable,
`ifdef TEST_PATTERN_EN
    input  logic [1:0]             pattern_sel,
`endif
    output logic [CW-1:0]          hcount,
    output logic [CW-1:0]          vcount,
    output logic                   pix_req,
    input  logic [COLOR_DEPTH-1:0] pix_r,
    input  logic [COLOR_DEPTH-1:0] pix_g,
    input  logic [COLOR_DEPTH-1:0] pix_b,
    output logic [COLOR_DEPTH-1:0] vga_r,
    output logic [COLOR_DEPTH-1:0] vga_g,
    output logic [COLOR_DEPTH-1:0] vga_b,
    output logic                   vga_hs,
    output logic                   vga_vs,
    output logic                   vga_blank_n,
    output logic                   vga_sync_n,
    output logic                   line_start,
    output logic                   frame_start,
    output logic [15:0]            frame_count
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_ACT  = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT  = CW'(V_ACTIVE);
    localparam logic [CW-1:0] HS_BEG = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_END = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] VS_BEG = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_END = CW'(V_ACTIVE + V_FP + V_SYNC);

`ifdef TEST_PATTERN_EN
    localparam int DW = 4 + 3 * COLOR_DEPTH;
`else
    localparam int DW = 3;
`endif

    logic          h_wrap;
    logic          v_wrap;
    logic          hs_raw;
    logic          vs_raw;
    logic [DW-1:0] raw_vec;
    logic [DW-1:0] dly_vec;
    logic          d_act;
    logic          d_hs;
    logic          d_vs;

    logic [COLOR_DEPTH-1:0] src_r;
    logic [COLOR_DEPTH-1:0] src_g;
    logic [COLOR_DEPTH-1:0] src_b;

    assign h_wrap = (hcount == H_LAST);
    assign v_wrap = (vcount == V_LAST);

    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            hcount      <= '0;
            vcount      <= '0;
            frame_count <= '0;
        end else if (enable) begin
            if (h_wrap) begin
                hcount <= '0;
                if (v_wrap) begin
                    vcount      <= '0;
                    frame_count <= frame_count + 16'd1;
                end else begin
                    vcount <= vcount + 1'b1;
                end
            end else begin
                hcount <= hcount + 1'b1;
            end
        end
    end

    assign pix_req = enable && (hcount < H_ACT) && (vcount < V_ACT);
    assign hs_raw  = enable && (hcount >= HS_BEG) && (hcount < HS_END);
    assign vs_raw  = enable && (vcount >= VS_BEG) && (vcount < VS_END);

    // Pulses are gated by reset so they read 0 while reset is held.
    assign line_start  = enable && !reset && (hcount == '0);
    assign frame_start = line_start && (vcount == '0);
    assign vga_sync_n  = 1'b1;

`ifdef TEST_PATTERN_EN
    localparam int BAR_W = H_ACTIVE / 8;
    localparam logic [23:0] BAR_RGB = {3'b000, 3'b001, 3'b100, 3'b101,
                                       3'b010, 3'b011, 3'b110, 3'b111};

    logic [2:0]             bar;
    logic [2:0]             bar_rgb;
    logic                   pat_use;
    logic [COLOR_DEPTH-1:0] pat_r;
    logic [COLOR_DEPTH-1:0] pat_g;
    logic [COLOR_DEPTH-1:0] pat_b;

    always_comb begin
        bar = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if (hcount >= CW'(k * BAR_W)) bar = bar + 3'd1;
        end
        bar_rgb = BAR_RGB[bar*3 +: 3];
        pat_use = (pattern_sel != 2'd0);
        pat_r   = '0;
        pat_g   = '0;
        pat_b   = '0;
        case (pattern_sel)
            2'd1: begin
                pat_r = {COLOR_DEPTH{bar_rgb[2]}};
                pat_g = {COLOR_DEPTH{bar_rgb[1]}};
                pat_b = {COLOR_DEPTH{bar_rgb[0]}};
            end
            2'd2: begin
                pat_r = {COLOR_DEPTH{hcount[5] ^ vcount[5]}};
                pat_g = pat_r;
                pat_b = pat_r;
            end
            2'd3: begin
                pat_r = COLOR_DEPTH'(hcount);
                pat_g = pat_r;
                pat_b = pat_r;
            end
            default: ;
        endcase
    end

    assign raw_vec = {pat_use, pat_r, pat_g, pat_b, pix_req, hs_raw, vs_raw};

    always_comb begin
        src_r = pix_r;
        src_g = pix_g;
        src_b = pix_b;
        if (dly_vec[DW-1]) begin
            src_r = dly_vec[DW-2 -: COLOR_DEPTH];
            src_g = dly_vec[DW-2-COLOR_DEPTH -: COLOR_DEPTH];
            src_b = dly_vec[DW-2-2*COLOR_DEPTH -: COLOR_DEPTH];
        end
    end
`else
    assign raw_vec = {pix_req, hs_raw, vs_raw};
    assign src_r   = pix_r;
    assign src_g   = pix_g;
    assign src_b   = pix_b;
`endif

    // Control is delayed to line up with the source's fixed latency.
    generate
        if (PIPE_LAT == 0) begin : g_nodly
            assign dly_vec = raw_vec;
        end else begin : g_dly
            logic [DW-1:0] sr [PIPE_LAT];
            always_ff @(posedge vga_clk or posedge reset) begin
                if (reset) begin
                    for (int i = 0; i < PIPE_LAT; i++) sr[i] <= '0;
                end else begin
                    sr[0] <= raw_vec;
                    for (int i = 1; i < PIPE_LAT; i++) sr[i] <= sr[i-1];
                end
            end
            assign dly_vec = sr[PIPE_LAT-1];
        end
    endgenerate

    assign d_act = dly_vec[2];
    assign d_hs  = dly_vec[1];
    assign d_vs  = dly_vec[0];

    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            vga_r       <= '0;
            vga_g       <= '0;
            vga_b       <= '0;
            vga_blank_n <= 1'b0;
            vga_hs      <= ~HS_POL;
            vga_vs      <= ~VS_POL;
        end else begin
            vga_r       <= d_act ? src_r : '0;
            vga_g       <= d_act ? src_g : '0;
            vga_b       <= d_act ? src_b : '0;
            vga_blank_n <= d_act;
            vga_hs      <= d_hs ? HS_POL : ~HS_POL;
            vga_vs      <= d_vs ? VS_POL : ~VS_POL;
        end
    end

endmodule

// File: tb/tb_vga_video_timing.sv
// Self-checking bench for vga_video_timing on a reduced raster.
// Random pixel data and enable checked against a cycle-history model.
module tb_vga_video_timing;

    localparam int   HA  = 16;
    localparam int   HFP = 2;
    localparam int   HSY = 3;
    localparam int   HBP = 3;
    localparam int   VA  = 6;
    localparam int   VFP = 1;
    localparam int   VSY = 2;
    localparam int   VBP = 1;
    localparam int   HT  = HA + HFP + HSY + HBP;
    localparam int   VT  = VA + VFP + VSY + VBP;
    localparam int   PL  = 2;
    localparam int   CD  = 8;
    localparam int   CW  = 10;
    localparam logic HP  = 1'b1;
    localparam logic VP  = 1'b0;

    logic          vga_clk;
    logic          reset;
    logic          enable;
    logic [CW-1:0] hcount;
    logic [CW-1:0] vcount;
    logic          pix_req;
    logic [CD-1:0] pix_r, pix_g, pix_b;
    logic [CD-1:0] vga_r, vga_g, vga_b;
    logic          vga_hs, vga_vs, vga_blank_n, vga_sync_n;
    logic          line_start, frame_start;
    logic [15:0]   frame_count;

    vga_video_timing #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
        .HS_POL(HP), .VS_POL(VP), .PIPE_LAT(PL),
        .COLOR_DEPTH(CD), .CW(CW)
    ) dut (
        .vga_clk(vga_clk),
        .reset(reset),
        .enable(enable),
        .hcount(hcount),
        .vcount(vcount),
        .pix_req(pix_req),
        .pix_r(pix_r),
        .pix_g(pix_g),
        .pix_b(pix_b),
        .vga_r(vga_r),
        .vga_g(vga_g),
        .vga_b(vga_b),
        .vga_hs(vga_hs),
        .vga_vs(vga_vs),
        .vga_blank_n(vga_blank_n),
        .vga_sync_n(vga_sync_n),
        .line_start(line_start),
        .frame_start(frame_start),
        .frame_count(frame_count)
    );

    initial vga_clk = 1'b0;
    always #5 vga_clk = ~vga_clk;

    int nchk;
    int nerr;
    int mh, mv, mfc, t;
    bit          act_h [16];
    bit          hs_h  [16];
    bit          vs_h  [16];
    logic [23:0] pix_h [16];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        nchk++;
        assert (obs === exp)
        else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        logic hs_idle, vs_idle;
        hs_idle = !HP;
        vs_idle = !VP;
        chk({tag, "_hcount"}, hcount, 0);
        chk({tag, "_vcount"}, vcount, 0);
        chk({tag, "_frame_count"}, frame_count, 0);
        chk({tag, "_rgb"}, {vga_r, vga_g, vga_b}, 0);
        chk({tag, "_blank_n"}, vga_blank_n, 0);
        chk({tag, "_hs"}, vga_hs, hs_idle);
        chk({tag, "_vs"}, vga_vs, vs_idle);
        chk({tag, "_line_start"}, line_start, 0);
        chk({tag, "_frame_start"}, frame_start, 0);
    endtask

    task automatic model_reset();
        mh  = 0;
        mv  = 0;
        mfc = 0;
        t   = 0;
    endtask

    // One pixel clock: drive inputs, check, record history, advance model.
    task automatic cycle(input bit en);
        int          d;
        bit          e_act, e_hs, e_vs;
        logic        x_hs, x_vs;
        logic [23:0] e_rgb;
        bit          act_now;
        enable = en;
        {pix_r, pix_g, pix_b} = 24'($urandom);
        #1;
        d     = t - 1 - PL;
        e_act = 1'b0;
        e_hs  = 1'b0;
        e_vs  = 1'b0;
        e_rgb = '0;
        if (d >= 0) begin
            e_act = act_h[d % 16];
            e_hs  = hs_h[d % 16];
            e_vs  = vs_h[d % 16];
            if (e_act) e_rgb = pix_h[(t - 1) % 16];
        end
        x_hs = e_hs ? HP : !HP;
        x_vs = e_vs ? VP : !VP;
        act_now = en && (mh < HA) && (mv < VA);
        chk("hcount", hcount, mh);
        chk("vcount", vcount, mv);
        chk("frame_count", frame_count, mfc);
        chk("pix_req", pix_req, act_now);
        chk("line_start", line_start, en && mh == 0);
        chk("frame_start", frame_start, en && mh == 0 && mv == 0);
        chk("blank_n", vga_blank_n, e_act);
        chk("hs", vga_hs, x_hs);
        chk("vs", vga_vs, x_vs);
        chk("rgb", {vga_r, vga_g, vga_b}, e_rgb);
        chk("sync_n", vga_sync_n, 1);
        act_h[t % 16] = act_now;
        hs_h[t % 16]  = en && (mh >= HA + HFP) && (mh < HA + HFP + HSY);
        vs_h[t % 16]  = en && (mv >= VA + VFP) && (mv < VA + VFP + VSY);
        pix_h[t % 16] = {pix_r, pix_g, pix_b};
        if (en) begin
            if (mh == HT - 1) begin
                mh = 0;
                if (mv == VT - 1) begin
                    mv  = 0;
                    mfc = (mfc + 1) % 65536;
                end else begin
                    mv++;
                end
            end else begin
                mh++;
            end
        end
        t++;
        @(posedge vga_clk);
        #1;
    endtask

    initial begin
        nchk   = 0;
        nerr   = 0;
        reset  = 1'b1;
        enable = 1'b0;
        pix_r  = '0;
        pix_g  = '0;
        pix_b  = '0;
        model_reset();

        repeat (3) @(posedge vga_clk);
        #1;
        chk_reset("por");
        enable = 1'b1;
        #1;
        chk_reset("por_en");
        reset = 1'b0;
        model_reset();

        repeat (300) cycle(1'b1);

        for (int i = 0; i < HT && mh != 13; i++) cycle(1'b1);
        chk("pause_pos", hcount, 13);
        repeat (10) cycle(1'b0);
        repeat (40) cycle(1'b1);

        repeat (1500) cycle($urandom_range(0, 99) < 85);

        for (int i = 0; i < HT && mh != 7; i++) cycle(1'b1);
        #2;
        reset  = 1'b1;
        enable = 1'b1;
        #1;
        chk_reset("async");
        @(posedge vga_clk);
        @(posedge vga_clk);
        #1;
        reset = 1'b0;
        model_reset();
        repeat (600) cycle(1'b1);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
